// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on the user switch, rings on a new alarm-time match,
// handles a limited number of snoozes and selects what the display shows.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OFF      | alarm switch off, everything cleared
// ARMED    | waiting for a fresh rising edge of the alarm-time match
// RINGING  | buzzer toggling each second, ring_cnt counts seconds rung
// SNOOZING | buzzer silent, snooze_left counts down to the next ring
module alarm_sequencer #(
   parameter int SNOOZE_SECS = 540,
   parameter int RING_SECS   = 60,
   parameter int MAX_SNOOZE  = 3,
   parameter int SHOW_SECS   = 5
) (
   input  logic       Clock_1sec,
   input  logic       reset,
   input  logic       alarm,
   input  logic       arm,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   input  logic       show_btn,
   input  logic       set_mode,
   output logic       alarm_enable,
   output logic       buzzer,
   output logic [1:0] display_state,
   output logic [9:0] snooze_left,
   output logic [1:0] snooze_count
);

   typedef enum logic [1:0] {OFF, ARMED, RINGING, SNOOZING} state_t;

   state_t      state, state_nxt;
   logic [7:0]  ring_cnt, ring_nxt;
   logic [9:0]  snooze_nxt;
   logic [1:0]  count_nxt;
   logic [3:0]  show_cnt, show_nxt;
   logic        alarm_prev;
   logic        show_prev;
   logic        alarm_rise;
   logic        snooze_event;

   assign alarm_rise = alarm & ~alarm_prev;

   // Next-state and counter values; outputs are registered from these so
   // they describe the state being entered, not the one being left.
   always_comb begin
      state_nxt    = state;
      ring_nxt     = ring_cnt;
      snooze_nxt   = snooze_left;
      count_nxt    = snooze_count;
      snooze_event = 1'b0;

      if (!arm) begin
         state_nxt  = OFF;
         ring_nxt   = 8'd0;
         snooze_nxt = 10'd0;
         count_nxt  = 2'd0;
      end else begin
         case (state)
            OFF: begin
               state_nxt = ARMED;
            end
            ARMED: begin
               if (alarm_rise) begin
                  state_nxt = RINGING;
                  ring_nxt  = 8'd0;
                  count_nxt = 2'd0;
               end
            end
            RINGING: begin
               if (stop_btn) begin
                  state_nxt = ARMED;
                  ring_nxt  = 8'd0;
               end else if (snooze_btn || (ring_cnt == 8'(RING_SECS - 1))) begin
                  snooze_event = 1'b1;
               end else if (ring_cnt != 8'hFF) begin
                  ring_nxt = ring_cnt + 8'd1;
               end
               if (snooze_event) begin
                  ring_nxt = 8'd0;
                  if (snooze_count < 2'(MAX_SNOOZE)) begin
                     state_nxt  = SNOOZING;
                     snooze_nxt = 10'(SNOOZE_SECS);
                     count_nxt  = snooze_count + 2'd1;
                  end else begin
                     state_nxt = ARMED;
                  end
               end
            end
            SNOOZING: begin
               if (stop_btn) begin
                  state_nxt  = ARMED;
                  snooze_nxt = 10'd0;
               end else if (snooze_left <= 10'd1) begin
                  state_nxt  = RINGING;
                  ring_nxt   = 8'd0;
                  snooze_nxt = 10'd0;
               end else begin
                  snooze_nxt = snooze_left - 10'd1;
               end
            end
            default: begin
               state_nxt = OFF;
            end
         endcase
      end

      if (show_btn && !show_prev) begin
         show_nxt = 4'(SHOW_SECS);
      end else if (show_cnt != 4'd0) begin
         show_nxt = show_cnt - 4'd1;
      end else begin
         show_nxt = 4'd0;
      end
   end

   // State, counters and registered outputs; reset silences the buzzer at once.
   always_ff @(posedge Clock_1sec or posedge reset) begin
      if (reset) begin
         state         <= OFF;
         ring_cnt      <= 8'd0;
         snooze_left   <= 10'd0;
         snooze_count  <= 2'd0;
         show_cnt      <= 4'd0;
         alarm_prev    <= 1'b0;
         show_prev     <= 1'b0;
         buzzer        <= 1'b0;
         alarm_enable  <= 1'b0;
         display_state <= 2'b00;
      end else begin
         state        <= state_nxt;
         ring_cnt     <= ring_nxt;
         snooze_left  <= snooze_nxt;
         snooze_count <= count_nxt;
         show_cnt     <= show_nxt;
         alarm_prev   <= alarm;
         show_prev    <= show_btn;
         buzzer       <= (state_nxt == RINGING) && !ring_nxt[0];
         alarm_enable <= (state_nxt != OFF);
         if (set_mode)
            display_state <= 2'b10;
         else if ((state_nxt == RINGING) || (show_nxt != 4'd0))
            display_state <= 2'b01;
         else
            display_state <= 2'b00;
      end
   end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter SNOOZE_SECS, default 540, snooze duration in seconds (1..1023).
REQ-002 The block SHALL have parameter RING_SECS, default 60, ring duration before auto-snooze (2..255).
REQ-003 The block SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..3).
REQ-004 The block SHALL have parameter SHOW_SECS, default 5, alarm-time display hold in seconds (1..15).
REQ-005 The block SHALL have port Clock_1sec  input  1  1 Hz clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port alarm  input  1  time-match flag from the clock logic; high for the whole matching minute.
REQ-008 The block SHALL have port arm  input  1  user alarm switch level.
REQ-009 The block SHALL have port snooze_btn  input  1  snooze request, level sampled per cycle.
REQ-010 The block SHALL have port stop_btn  input  1  stop request, level sampled per cycle.
REQ-011 The block SHALL have port show_btn  input  1  request to display the alarm time.
REQ-012 The block SHALL have port set_mode  input  1  user is entering a time.
REQ-013 The block SHALL have port alarm_enable  output  1  enable to the clock logic, registered.
REQ-014 The block SHALL have port buzzer  output  1  buzzer drive, registered.
REQ-015 The block SHALL have port display_state  output  2  display select: 00 current, 01 alarm, 10 input; registered.
REQ-016 The block SHALL have port snooze_left  output  10  seconds remaining in the current snooze.
REQ-017 The block SHALL have port snooze_count  output  2  snoozes used in the current alarm event.

Function
REQ-018 The FSM SHALL have states OFF, ARMED, RINGING, SNOOZING.
REQ-019 A rising edge of alarm SHALL be detected as alarm=1 with alarm_prev=0; alarm_prev SHALL be updated every cycle in every state.
REQ-020 Transitions SHALL be: OFF->ARMED when arm=1; ARMED->RINGING on a rising edge of alarm, with ring_cnt=0 and snooze_count=0.
REQ-021 In RINGING: stop_btn=1 -> ARMED; otherwise snooze_btn=1, or ring_cnt=RING_SECS-1, -> snooze event.
REQ-022 A snooze event SHALL go to SNOOZING (snooze_left=SNOOZE_SECS, snooze_count+1) if snooze_count<MAX_SNOOZE, else to ARMED.
REQ-023 In SNOOZING: snooze_left SHALL decrement by 1 per cycle; stop_btn=1 -> ARMED; snooze_left=1 -> RINGING with ring_cnt=0, snooze_count held.
REQ-024 arm=0 SHALL force OFF on the next edge from any state, clearing ring_cnt, snooze_left and snooze_count.
REQ-025 Priority SHALL be arm=0 > stop_btn > snooze_btn > ring timeout; snooze_btn in SNOOZING SHALL be ignored.
REQ-026 Rising edges of alarm in OFF, RINGING or SNOOZING SHALL be ignored; an alarm still high after stop SHALL NOT retrigger.
REQ-027 buzzer SHALL be 1 exactly when the next state is RINGING and the next ring_cnt is even; the first RINGING cycle has buzzer=1.
REQ-028 alarm_enable SHALL be 1 exactly when the next state is not OFF.
REQ-029 A rising edge of show_btn SHALL load show_cnt=SHOW_SECS; show_cnt SHALL decrement to 0.
REQ-030 display_state SHALL be 10 if set_mode=1; else 01 if RINGING or show_cnt>0; else 00.
REQ-031 ring_cnt SHALL be 8 bits and saturate; snooze_left SHALL NOT underflow and SHALL read 0 outside SNOOZING.

Reset
REQ-032 Under reset: state OFF, buzzer 0, alarm_enable 0, display_state 00, snooze_left 0, snooze_count 0, ring_cnt 0, show_cnt 0, alarm_prev 0.
REQ-033 reset mid-ring or mid-snooze SHALL immediately silence buzzer; after release with arm=1 the block SHALL enter ARMED without triggering on an alarm already high.

Verification
REQ-034 arm=1, alarm 0->1 while ARMED -> RINGING; buzzer 1,0,1,0 on consecutive cycles; display_state=01.
REQ-035 Override SNOOZE_SECS=5: snooze_btn pulse in RINGING -> snooze_left 5,4,3,2,1, then RINGING, snooze_count=1.
REQ-036 MAX_SNOOZE=1: second snooze_btn -> ARMED, buzzer 0; alarm held high for a further 30 cycles -> no re-ring.
REQ-037 RING_SECS=4, no buttons -> auto-snooze after 4 RINGING cycles; stop_btn and snooze_btn together -> ARMED.
REQ-038 arm 1->0 during SNOOZING -> OFF next edge, alarm_enable=0, snooze_left=0; async reset mid-RINGING -> buzzer 0 before the next clock edge.
REQ-039 show_btn pulse with SHOW_SECS=5 -> display_state=01 for 5 cycles, then 00; set_mode=1 overrides to 10.
